uart_probe: RTL and testbench

Byte-command debug probe. It receives opcode/argument bytes on a valid/ready byte stream, typically from a UART receiver, and returns response bytes on a valid/ready stream, typically to a UART transmitter. It exposes a 32-bit general-purpose output register and samples a 32-bit general-purpose input. It also drives a single-beat AXI4-Lite-style master with a 32-bit address register and data register, so a host can peek and poke the system bus.

---
 rtl/uart_probe_pkg.sv | 28 ++
 rtl/uart_probe_if.sv | 33 +++
 rtl/uart_probe_axi_master.sv | 91 +++++++++
 rtl/uart_probe.sv | 137 +++++++++++++
 tb/tb_uart_probe.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/uart_probe_pkg.sv
// Shared definitions for the byte-command debug probe: opcodes, FSM states and
// small decode helpers.
package uart_probe_pkg;

  localparam logic [7:0] CMD_GPI_RD0 = 8'd2,  CMD_GPI_RD1 = 8'd3,  CMD_GPI_RD2 = 8'd4,  CMD_GPI_RD3 = 8'd5;
  localparam logic [7:0] CMD_GPO_RD0 = 8'd6,  CMD_GPO_RD1 = 8'd7,  CMD_GPO_RD2 = 8'd8,  CMD_GPO_RD3 = 8'd9;
  localparam logic [7:0] CMD_GPO_WR0 = 8'd10, CMD_GPO_WR1 = 8'd11, CMD_GPO_WR2 = 8'd12, CMD_GPO_WR3 = 8'd13;
  localparam logic [7:0] CMD_AXI_RD0 = 8'd14, CMD_AXI_RD1 = 8'd15, CMD_AXI_RD2 = 8'd16, CMD_AXI_RD3 = 8'd17;
  localparam logic [7:0] CMD_AXI_WR0 = 8'd18, CMD_AXI_WR1 = 8'd19, CMD_AXI_WR2 = 8'd20, CMD_AXI_WR3 = 8'd21;
  localparam logic [7:0] CMD_AXI_RD  = 8'd22, CMD_AXI_WR  = 8'd23, CMD_AXI_RDC = 8'd24, CMD_AXI_WRC = 8'd25;

  typedef enum logic [1:0] {ST_IDLE, ST_ARG, ST_RESP, ST_AXI} state_t;
  typedef enum logic [2:0] {AX_IDLE, AX_AR, AX_R, AX_AWW, AX_B} axi_state_t;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] n);
    return w[{n, 3'b000} +: 8];
  endfunction

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Every byte-indexed opcode group starts at a base that is 2 mod 4.
  function automatic logic [1:0] op_byte(input logic [7:0] op);
    return op[1:0] ^ 2'b10;
  endfunction

endpackage

// File: rtl/uart_probe_if.sv
// Bundle of the probe's byte streams, GPIO and AXI4-Lite master signals.
// master = probe side, slave = host/system side.
interface uart_probe_if;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic [31:0] gpo, gpi;
  logic [31:0] m_axi_araddr, m_axi_awaddr, m_axi_wdata, m_axi_rdata;
  logic [2:0]  m_axi_arsize, m_axi_awsize;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic        m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_rready;
  logic        m_axi_arready, m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_rvalid;

  modport master (
    input  rx_valid, rx_data, tx_ready, gpi,
           m_axi_arready, m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_rvalid,
           m_axi_rdata, m_axi_rresp, m_axi_bresp,
    output rx_ready, tx_valid, tx_data, gpo,
           m_axi_araddr, m_axi_awaddr, m_axi_arsize, m_axi_awsize,
           m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_rready,
           m_axi_wdata, m_axi_wstrb
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, gpi,
           m_axi_arready, m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_rvalid,
           m_axi_rdata, m_axi_rresp, m_axi_bresp,
    input  rx_ready, tx_valid, tx_data, gpo,
           m_axi_araddr, m_axi_awaddr, m_axi_arsize, m_axi_awsize,
           m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_rready,
           m_axi_wdata, m_axi_wstrb
  );
endinterface

// File: rtl/uart_probe_axi_master.sv
// Single-beat AXI4-Lite master sequencer: AR->R for reads, AW+W->B for writes.
module uart_probe_axi_master
  import uart_probe_pkg::*;
(
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic        i_start_rd,
  input  logic        i_start_wr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_done_rd,
  output logic [1:0]  o_resp,
  output logic [31:0] o_rdata,
  output logic        o_arvalid,
  input  logic        i_arready,
  output logic        o_rready,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_bready,
  input  logic        i_bvalid,
  input  logic [1:0]  i_bresp
);

  axi_state_t  r_state, w_next;
  logic        r_awvalid, r_wvalid;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        w_aw_done, w_w_done;

  // AW and W complete independently; B waits for whichever finishes last.
  assign w_aw_done = !r_awvalid || i_awready;
  assign w_w_done  = !r_wvalid  || i_wready;

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) r_state <= AX_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      AX_IDLE: if (i_start_rd) w_next = AX_AR;
               else if (i_start_wr) w_next = AX_AWW;
      AX_AR:   if (i_arready) w_next = AX_R;
      AX_R:    if (i_rvalid) w_next = AX_IDLE;
      AX_AWW:  if (w_aw_done && w_w_done) w_next = AX_B;
      AX_B:    if (i_bvalid) w_next = AX_IDLE;
      default: w_next = AX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (r_state == AX_IDLE && !i_start_rd && i_start_wr) begin
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_wdata   <= i_wdata;
      r_wstrb   <= i_wstrb;
    end else begin
      if (i_awready) r_awvalid <= 1'b0;
      if (i_wready)  r_wvalid  <= 1'b0;
    end
  end

  assign o_busy    = (r_state != AX_IDLE);
  assign o_done    = (r_state == AX_R && i_rvalid) || (r_state == AX_B && i_bvalid);
  assign o_done_rd = (r_state == AX_R);
  assign o_resp    = (r_state == AX_R) ? i_rresp : i_bresp;
  assign o_rdata   = i_rdata;
  assign o_arvalid = (r_state == AX_AR);
  assign o_rready  = (r_state == AX_R);
  assign o_bready  = (r_state == AX_B);
  assign o_awvalid = r_awvalid;
  assign o_wvalid  = r_wvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;

endmodule

// File: rtl/uart_probe.sv
// Byte-command debug probe: decodes opcode/argument bytes, owns the GPO,
// address, data and control registers, and launches single AXI beats.
module uart_probe
  import uart_probe_pkg::*;
(
  input  logic clk,
  input  logic m_aresetn,
  uart_probe_if.master bus
);

  state_t      r_state, w_next;
  logic [7:0]  r_op, r_tx_data, w_resp_byte, w_ctrl;
  logic        r_tx_valid, r_rx_ready;
  logic [31:0] r_gpo, r_addr, r_data, w_rdata;
  logic [1:0]  r_ctrl_resp, w_resp, w_rx_n, w_arg_n;
  logic        w_rx_hs, w_tx_hs, w_resp_ld, w_start_rd, w_start_wr, w_gpo_we, w_addr_we;
  logic        w_busy, w_done, w_done_rd;

  assign w_rx_hs = bus.rx_valid && r_rx_ready;
  assign w_tx_hs = r_tx_valid && bus.tx_ready;
  assign w_rx_n  = op_byte(bus.rx_data);
  assign w_arg_n = op_byte(r_op);
  assign w_ctrl  = {4'b0000, r_ctrl_resp, w_busy, 1'b0};

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_resp_ld   = 1'b0;
    w_resp_byte = '0;
    w_start_rd  = 1'b0;
    w_start_wr  = 1'b0;
    w_gpo_we    = 1'b0;
    w_addr_we   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_rx_hs) begin
        if (in_range(bus.rx_data, CMD_GPI_RD0, CMD_GPI_RD3)) begin
          w_resp_ld = 1'b1; w_resp_byte = byte_sel(bus.gpi, w_rx_n);
        end else if (in_range(bus.rx_data, CMD_GPO_RD0, CMD_GPO_RD3)) begin
          w_resp_ld = 1'b1; w_resp_byte = byte_sel(r_gpo, w_rx_n);
        end else if (in_range(bus.rx_data, CMD_AXI_RD0, CMD_AXI_RD3)) begin
          w_resp_ld = 1'b1; w_resp_byte = byte_sel(r_addr, w_rx_n);
        end else if (bus.rx_data == CMD_AXI_RD) begin
          w_resp_ld = 1'b1; w_resp_byte = r_data[7:0];
        end else if (bus.rx_data == CMD_AXI_RDC) begin
          w_resp_ld = 1'b1; w_resp_byte = w_ctrl;
        end else if (in_range(bus.rx_data, CMD_GPO_WR0, CMD_GPO_WR3) ||
                     in_range(bus.rx_data, CMD_AXI_WR0, CMD_AXI_WR3) ||
                     bus.rx_data == CMD_AXI_WR || bus.rx_data == CMD_AXI_WRC) begin
          w_next = ST_ARG;
        end
        if (w_resp_ld) w_next = ST_RESP;
      end
      ST_ARG: if (w_rx_hs) begin
        w_next = ST_IDLE;
        if (in_range(r_op, CMD_GPO_WR0, CMD_GPO_WR3)) w_gpo_we = 1'b1;
        else if (in_range(r_op, CMD_AXI_WR0, CMD_AXI_WR3)) w_addr_we = 1'b1;
        else if (r_op == CMD_AXI_WR) begin
          w_start_wr = 1'b1; w_next = ST_AXI;
        end else if (r_op == CMD_AXI_WRC && bus.rx_data[0]) begin
          w_start_rd = 1'b1; w_next = ST_AXI;
        end
      end
      ST_RESP: if (w_tx_hs) w_next = ST_IDLE;
      ST_AXI:  if (w_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered so they sit low through reset and the
  // first edge after release.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_rx_ready  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_op        <= '0;
      r_gpo       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_ctrl_resp <= '0;
    end else begin
      r_rx_ready <= (w_next == ST_IDLE) || (w_next == ST_ARG);
      r_tx_valid <= (w_next == ST_RESP);
      if (w_resp_ld) r_tx_data <= w_resp_byte;
      if (r_state == ST_IDLE && w_rx_hs) r_op <= bus.rx_data;
      if (w_gpo_we)  r_gpo[{w_arg_n, 3'b000} +: 8]  <= bus.rx_data;
      if (w_addr_we) r_addr[{w_arg_n, 3'b000} +: 8] <= bus.rx_data;
      if (w_done) begin
        r_ctrl_resp <= w_resp;
        if (w_done_rd) r_data <= w_rdata;
      end
    end
  end

  uart_probe_axi_master u_axi (
    .clk        (clk),
    .m_aresetn  (m_aresetn),
    .i_start_rd (w_start_rd),
    .i_start_wr (w_start_wr),
    .i_wdata    ({4{bus.rx_data}}),
    .i_wstrb    (4'b0001 << r_addr[1:0]),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_done_rd  (w_done_rd),
    .o_resp     (w_resp),
    .o_rdata    (w_rdata),
    .o_arvalid  (bus.m_axi_arvalid),
    .i_arready  (bus.m_axi_arready),
    .o_rready   (bus.m_axi_rready),
    .i_rvalid   (bus.m_axi_rvalid),
    .i_rdata    (bus.m_axi_rdata),
    .i_rresp    (bus.m_axi_rresp),
    .o_awvalid  (bus.m_axi_awvalid),
    .i_awready  (bus.m_axi_awready),
    .o_wvalid   (bus.m_axi_wvalid),
    .i_wready   (bus.m_axi_wready),
    .o_wdata    (bus.m_axi_wdata),
    .o_wstrb    (bus.m_axi_wstrb),
    .o_bready   (bus.m_axi_bready),
    .i_bvalid   (bus.m_axi_bvalid),
    .i_bresp    (bus.m_axi_bresp)
  );

  assign bus.rx_ready     = r_rx_ready;
  assign bus.tx_valid     = r_tx_valid;
  assign bus.tx_data      = r_tx_data;
  assign bus.gpo          = r_gpo;
  assign bus.m_axi_araddr = r_addr;
  assign bus.m_axi_awaddr = r_addr;
  assign bus.m_axi_arsize = 3'b010;
  assign bus.m_axi_awsize = 3'b000;

endmodule

// File: tb/tb_uart_probe.sv
// Directed bench for uart_probe: command bytes in, response bytes and AXI beats
// checked against hand-computed values.
module tb_uart_probe;

  logic clk = 1'b0;
  logic m_aresetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  uart_probe_if bus();

  uart_probe u_dut (
    .clk       (clk),
    .m_aresetn (m_aresetn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("rx_accept", {31'b0, bus.rx_ready}, 32'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    bus.tx_ready = 1'b1;
    while (!bus.tx_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_vld"}, {31'b0, bus.tx_valid}, 32'd1);
    chk(tag, {24'b0, bus.tx_data}, {24'b0, exp});
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    chk({tag, "_drop"}, {31'b0, bus.tx_valid}, 32'd0);
  endtask

  initial begin
    bus.rx_valid = 0; bus.rx_data = 0; bus.tx_ready = 0; bus.gpi = 32'hA1B2C3D4;
    bus.m_axi_arready = 0; bus.m_axi_awready = 0; bus.m_axi_wready = 0;
    bus.m_axi_bvalid = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0;
    bus.m_axi_rresp = 0; bus.m_axi_bresp = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data",  {24'b0, bus.tx_data}, 32'd0);
    chk("rst_gpo",      bus.gpo, 32'd0);
    chk("rst_araddr",   bus.m_axi_araddr, 32'd0);
    chk("rst_valids",   {28'b0, bus.m_axi_arvalid, bus.m_axi_awvalid, bus.m_axi_wvalid,
                         bus.m_axi_bready}, 32'd0);
    chk("arsize", {29'b0, bus.m_axi_arsize}, 32'd2);
    chk("awsize", {29'b0, bus.m_axi_awsize}, 32'd0);
    m_aresetn = 1'b1;
    @(posedge clk); #1;
    chk("rx_ready_after_rst", {31'b0, bus.rx_ready}, 32'd1);

    // GPI reads
    send_byte(8'd4);
    chk("resp_latency", {31'b0, bus.tx_valid}, 32'd1);
    recv_byte("gpi_b2", 8'hB2);
    send_byte(8'd2);
    recv_byte("gpi_b0", 8'hD4);

    // GPO writes and readback
    send_byte(8'd10); send_byte(8'h11);
    chk("gpo_b0", bus.gpo, 32'h00000011);
    send_byte(8'd12); send_byte(8'h5A);
    chk("gpo_b2", bus.gpo, 32'h005A0011);
    send_byte(8'd8);
    recv_byte("gpo_rd2", 8'h5A);

    // Address register
    send_byte(8'd18); send_byte(8'h10);
    send_byte(8'd19); send_byte(8'h32);
    send_byte(8'd20); send_byte(8'h54);
    send_byte(8'd21); send_byte(8'h76);
    send_byte(8'd16);
    recv_byte("addr_rd2", 8'h54);
    chk("araddr", bus.m_axi_araddr, 32'h76543210);

    // Ignored opcode and a WRC without the start bit
    send_byte(8'd30);
    chk("ign_no_resp", {31'b0, bus.tx_valid}, 32'd0);
    send_byte(8'd25); send_byte(8'h00);
    chk("wrc0_no_ar", {31'b0, bus.m_axi_arvalid}, 32'd0);
    chk("wrc0_rx_rdy", {31'b0, bus.rx_ready}, 32'd1);

    // AXI write to 0x76543211
    send_byte(8'd18); send_byte(8'h11);
    send_byte(8'd23); send_byte(8'hEE);
    chk("aw_valid", {30'b0, bus.m_axi_awvalid, bus.m_axi_wvalid}, 32'd3);
    chk("awaddr", bus.m_axi_awaddr, 32'h76543211);
    chk("wdata",  bus.m_axi_wdata, 32'hEEEEEEEE);
    chk("wstrb",  {28'b0, bus.m_axi_wstrb}, 32'h2);
    chk("wr_rx_stall", {31'b0, bus.rx_ready}, 32'd0);
    bus.m_axi_awready = 1'b1;
    @(posedge clk); #1;
    bus.m_axi_awready = 1'b0;
    chk("aw_drop_w_hold", {30'b0, bus.m_axi_awvalid, bus.m_axi_wvalid}, 32'd1);
    chk("no_bready_yet", {31'b0, bus.m_axi_bready}, 32'd0);
    bus.m_axi_wready = 1'b1;
    @(posedge clk); #1;
    bus.m_axi_wready = 1'b0;
    chk("w_drop", {30'b0, bus.m_axi_awvalid, bus.m_axi_wvalid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bready_wait", {31'b0, bus.m_axi_bready}, 32'd1);
    chk("b_rx_stall", {31'b0, bus.rx_ready}, 32'd0);
    bus.m_axi_bvalid = 1'b1;
    @(posedge clk); #1;
    bus.m_axi_bvalid = 1'b0;
    chk("b_done", {31'b0, bus.m_axi_bready}, 32'd0);
    chk("wr_rx_resume", {31'b0, bus.rx_ready}, 32'd1);

    // AXI read, slave answers after 2 cycles
    send_byte(8'd25); send_byte(8'h01);
    chk("arvalid", {31'b0, bus.m_axi_arvalid}, 32'd1);
    chk("rd_araddr", bus.m_axi_araddr, 32'h76543211);
    @(posedge clk); #1;
    chk("arvalid_hold", {31'b0, bus.m_axi_arvalid}, 32'd1);
    bus.m_axi_arready = 1'b1;
    @(posedge clk); #1;
    bus.m_axi_arready = 1'b0;
    chk("rready", {30'b0, bus.m_axi_arvalid, bus.m_axi_rready}, 32'd1);
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'hCAFEF00D; bus.m_axi_rresp = 2'b10;
    @(posedge clk); #1;
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = 32'h0;
    chk("r_done", {31'b0, bus.m_axi_rready}, 32'd0);
    send_byte(8'd22);
    recv_byte("data_rd", 8'h0D);
    send_byte(8'd24);
    recv_byte("ctrl_rd", 8'h08);

    // tx backpressure
    send_byte(8'd6);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {22'b0, bus.tx_valid, bus.rx_ready, bus.tx_data}, {22'b0, 2'b10, 8'h11});
      @(posedge clk); #1;
    end
    recv_byte("bp_rd", 8'h11);

    // Reset during an outstanding read address phase
    send_byte(8'd25); send_byte(8'h01);
    chk("ar_before_rst", {31'b0, bus.m_axi_arvalid}, 32'd1);
    #2;
    m_aresetn = 1'b0;
    #1;
    chk("rst_arvalid", {31'b0, bus.m_axi_arvalid}, 32'd0);
    chk("rst_gpo2",    bus.gpo, 32'd0);
    chk("rst_araddr2", bus.m_axi_araddr, 32'd0);
    chk("rst_rx_rdy2", {31'b0, bus.rx_ready}, 32'd0);
    chk("rst_tx_data2", {24'b0, bus.tx_data}, 32'd0);
    @(posedge clk); #1;
    m_aresetn = 1'b1;
    send_byte(8'd24);
    recv_byte("ctrl_after_rst", 8'h00);
    send_byte(8'd22);
    recv_byte("data_after_rst", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
